tone_sequencer: RTL and testbench

TONE_SEQUENCER -- requirements
Module: tone_sequencer

---
 rtl/tone_pkg.sv | 36 +++
 rtl/tone_period_rom.sv | 24 ++
 rtl/tone_sequencer.sv | 141 ++++++++++++++
 tb/tb_tone_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tone_pkg.sv
// Shared constants, state encoding and base period table for the tone sequencer.
package tone_pkg;

  // Tone code reserved for a rest; codes 12..14 are also played as silence.
  localparam logic [3:0] REST       = 4'd15;
  // Half-period of the wave is the prescale value shifted left by this amount.
  localparam int         HALF_SHIFT = 7;
  // Width of the prescale value P.
  localparam int         P_W        = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Octave-4 prescale per semitone, do..si; any other code yields zero.
  function automatic logic [P_W-1:0] base_period(input logic [3:0] tone);
    case (tone)
      4'd0:    base_period = 10'd470;
      4'd1:    base_period = 10'd444;
      4'd2:    base_period = 10'd419;
      4'd3:    base_period = 10'd395;
      4'd4:    base_period = 10'd373;
      4'd5:    base_period = 10'd352;
      4'd6:    base_period = 10'd333;
      4'd7:    base_period = 10'd314;
      4'd8:    base_period = 10'd296;
      4'd9:    base_period = 10'd280;
      4'd10:   base_period = 10'd264;
      4'd11:   base_period = 10'd249;
      default: base_period = '0;
    endcase
  endfunction

endpackage

// File: rtl/tone_period_rom.sv
// Combinational tone/octave to prescale lookup; silent codes map to zero.
module tone_period_rom
  import tone_pkg::*;
(
  input  logic [3:0]     tone,
  input  logic [1:0]     octave,
  output logic [P_W-1:0] period
);

  // Divide the base period by 2^oct, rounding half up.
  function automatic logic [P_W-1:0] octave_scale(input logic [P_W-1:0] base,
                                                  input logic [1:0]     oct);
    logic [P_W:0] sum;
    sum = {1'b0, base} + ((P_W+1)'(1) << (oct - 2'd1));
    return (oct == 2'd0) ? base : P_W'(sum >> oct);
  endfunction

  // Rests and unused codes give P = 0 so the sequencer keeps the wave low.
  always_comb begin
    if (tone == REST || tone > 4'd11) period = '0;
    else                              period = octave_scale(base_period(tone), octave);
  end

endmodule

// File: rtl/tone_sequencer.sv
// Note sequencer: one-deep note queue, square-wave tone generator, timed gaps.
module tone_sequencer
  import tone_pkg::*;
#(
  parameter int CLK_HZ    = 31_500_000,
  parameter int DUR_TICK  = 31_500,
  parameter int DUR_W     = 16,
  parameter int GAP_UNITS = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             note_valid,
  output logic             note_ready,
  input  logic [3:0]       note_tone,
  input  logic [1:0]       note_octave,
  input  logic [DUR_W-1:0] note_dur,
  input  logic             stop,
  output logic             audio_out,
  output logic             busy,
  output logic             note_done
);

  // A non-positive DUR_TICK falls back to a 1 ms unit derived from the clock.
  localparam int              DUR_TICK_EFF = (DUR_TICK > 0) ? DUR_TICK : (CLK_HZ / 1000);
  localparam int              TICK_W       = (DUR_TICK_EFF > 1) ? $clog2(DUR_TICK_EFF) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(DUR_TICK_EFF - 1);
  localparam int              HP_W         = P_W + HALF_SHIFT;
  localparam bit              HAS_GAP      = (GAP_UNITS != 0);

  state_t             state, state_nx;
  logic               pend_vld;
  logic [3:0]         pend_tone;
  logic [1:0]         pend_oct;
  logic [DUR_W-1:0]   pend_dur;
  logic [P_W-1:0]     rom_p, act_p;
  logic [HP_W-1:0]    hp_cnt;
  logic [TICK_W-1:0]  tick_cnt;
  logic [DUR_W-1:0]   dur_cnt;
  logic               accept, ivl_end, play_end, take, zero, done;

  // Half-period reload value (P*128 - 1); a silent note never toggles.
  function automatic logic [HP_W-1:0] half_reload(input logic [P_W-1:0] p);
    return (p == '0) ? '0 : ((HP_W'(p) << HALF_SHIFT) - HP_W'(1));
  endfunction

  tone_period_rom u_rom (
    .tone   (pend_tone),
    .octave (pend_oct),
    .period (rom_p)
  );

  assign note_ready = !pend_vld && !stop;
  assign accept     = note_valid && note_ready;
  assign busy       = (state != IDLE) || pend_vld;
  // Last cycle of the current PLAY or GAP interval.
  assign ivl_end    = (tick_cnt == TICK_LAST) && (dur_cnt == DUR_W'(1));

  // Next-state decode: when to load the pending note and when a note completes.
  always_comb begin
    state_nx = state;
    play_end = (state == PLAY) && ivl_end;
    take     = 1'b0;
    if (pend_vld) begin
      case (state)
        IDLE:    take = 1'b1;
        GAP:     take = ivl_end;
        PLAY:    take = play_end && !HAS_GAP && (pend_dur != '0);
        default: take = 1'b0;
      endcase
    end
    zero = take && (pend_dur == '0);
    done = play_end || zero;
    if (take && !zero)              state_nx = PLAY;
    else if (done)                  state_nx = HAS_GAP ? GAP : IDLE;
    else if (state == GAP && ivl_end) state_nx = IDLE;
  end

  // Control: FSM state, pending flag, interval counters and the registered wave.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pend_vld  <= 1'b0;
      note_done <= 1'b0;
      audio_out <= 1'b0;
      hp_cnt    <= '0;
      tick_cnt  <= '0;
      dur_cnt   <= '0;
    end else if (stop) begin
      state     <= IDLE;
      pend_vld  <= 1'b0;
      note_done <= (state != IDLE);
      audio_out <= 1'b0;
      hp_cnt    <= '0;
      tick_cnt  <= '0;
      dur_cnt   <= '0;
    end else begin
      state     <= state_nx;
      note_done <= done;
      if (accept)    pend_vld <= 1'b1;
      else if (take) pend_vld <= 1'b0;
      if (take && !zero) begin
        dur_cnt   <= pend_dur;
        tick_cnt  <= '0;
        hp_cnt    <= half_reload(rom_p);
        audio_out <= 1'b0;
      end else if (done && HAS_GAP) begin
        dur_cnt   <= DUR_W'(GAP_UNITS);
        tick_cnt  <= '0;
        hp_cnt    <= '0;
        audio_out <= 1'b0;
      end else if (state_nx == IDLE) begin
        dur_cnt   <= '0;
        tick_cnt  <= '0;
        hp_cnt    <= '0;
        audio_out <= 1'b0;
      end else begin
        tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
        if (tick_cnt == TICK_LAST) dur_cnt <= dur_cnt - 1'b1;
        if (state == PLAY && act_p != '0) begin
          if (hp_cnt == '0) begin
            audio_out <= ~audio_out;
            hp_cnt    <= half_reload(act_p);
          end else begin
            hp_cnt <= hp_cnt - 1'b1;
          end
        end
      end
    end
  end

  // Data: pending note fields and the active prescale carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      pend_tone <= note_tone;
      pend_oct  <= note_octave;
      pend_dur  <= note_dur;
    end
    if (take) act_p <= rom_p;
  end

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer with DUR_TICK = 10 and a 20-cycle gap.
module tb_tone_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        note_valid;
  logic        note_ready;
  logic [3:0]  note_tone;
  logic [1:0]  note_octave;
  logic [15:0] note_dur;
  logic        stop;
  logic        audio_out;
  logic        busy;
  logic        note_done;

  logic [3:0]  rom_tone;
  logic [1:0]  rom_oct;
  logic [9:0]  rom_p;

  int total  = 0;
  int passed = 0;

  typedef struct {
    logic [3:0] tone;
    logic [1:0] oct;
    int         p;
  } rom_vec_t;

  rom_vec_t vecs [14];

  always #5 clk = ~clk;

  tone_sequencer #(
    .DUR_TICK  (10),
    .DUR_W     (16),
    .GAP_UNITS (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .note_valid  (note_valid),
    .note_ready  (note_ready),
    .note_tone   (note_tone),
    .note_octave (note_octave),
    .note_dur    (note_dur),
    .stop        (stop),
    .audio_out   (audio_out),
    .busy        (busy),
    .note_done   (note_done)
  );

  tone_period_rom u_rom (
    .tone   (rom_tone),
    .octave (rom_oct),
    .period (rom_p)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a note and hold it until the edge that accepts it.
  task automatic offer(input logic [3:0] t, input logic [1:0] o,
                       input logic [15:0] d, output int waits);
    waits = 0;
    note_tone = t; note_octave = o; note_dur = d; note_valid = 1'b1;
    while (!note_ready && waits < 1000) begin
      step();
      waits++;
    end
    if (!note_ready) check("offer_ready_timeout", 0, 1);
    step();
    note_valid = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int n, output int hi);
    n = 0; hi = 0;
    do begin
      step();
      n++;
      if (audio_out) hi++;
    end while (!note_done && n < limit);
  endtask

  task automatic wait_audio(input logic lvl, input int limit, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (audio_out != lvl && n < limit);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run not finished, got 2000000 ns, required less");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, hi, w;
    vecs[0]  = '{4'd0,  2'd0, 470};
    vecs[1]  = '{4'd9,  2'd2, 70};
    vecs[2]  = '{4'd0,  2'd1, 235};
    vecs[3]  = '{4'd11, 2'd3, 31};
    vecs[4]  = '{4'd1,  2'd1, 222};
    vecs[5]  = '{4'd5,  2'd2, 88};
    vecs[6]  = '{4'd2,  2'd3, 52};
    vecs[7]  = '{4'd3,  2'd1, 198};
    vecs[8]  = '{4'd7,  2'd3, 39};
    vecs[9]  = '{4'd15, 2'd0, 0};
    vecs[10] = '{4'd12, 2'd2, 0};
    vecs[11] = '{4'd14, 2'd1, 0};
    vecs[12] = '{4'd4,  2'd0, 373};
    vecs[13] = '{4'd10, 2'd2, 66};

    reset = 1'b1; stop = 1'b0; note_valid = 1'b0;
    note_tone = '0; note_octave = '0; note_dur = '0;
    rom_tone = '0; rom_oct = '0;

    for (int i = 0; i < 14; i++) begin
      rom_tone = vecs[i].tone;
      rom_oct  = vecs[i].oct;
      #1;
      check($sformatf("rom_t%0d_o%0d", vecs[i].tone, vecs[i].oct), int'(rom_p), vecs[i].p);
    end

    // Reset state
    repeat (3) step();
    check("reset_audio", int'(audio_out), 0);
    check("reset_done", int'(note_done), 0);
    check("reset_busy", int'(busy), 0);
    reset = 1'b0;
    #1;
    check("ready_after_reset", int'(note_ready), 1);

    // tone 9 oct 2 dur 3: load edge plus 30 PLAY cycles, then a 20-cycle gap
    offer(4'd9, 2'd2, 16'd3, w);
    check("busy_pending", int'(busy), 1);
    wait_done(100, n, hi);
    check("done_latency", n, 31);
    check("short_note_low", hi, 0);
    step();
    check("done_one_cycle", int'(note_done), 0);
    repeat (18) step();
    check("busy_in_gap", int'(busy), 1);
    step();
    check("idle_after_gap", int'(busy), 0);

    // P=70: toggles every 8960 cycles; second note waits in pending, then stop
    offer(4'd9, 2'd2, 16'd3000, w);
    offer(4'd0, 2'd0, 16'd5, w);
    check("accept_during_play", w, 1);
    wait_audio(1'b1, 20000, n);
    check("p70_first_rise", n, 8959);
    wait_audio(1'b0, 20000, n);
    check("p70_fall", n, 8960);
    wait_audio(1'b1, 20000, n);
    check("p70_rise", n, 8960);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("stop_audio", int'(audio_out), 0);
    check("stop_done", int'(note_done), 1);
    check("stop_busy", int'(busy), 0);
    step();
    check("stop_done_once", int'(note_done), 0);
    wait_done(50, n, hi);
    check("stop_pending_dropped", n, 50);
    check("stop_silent", hi, 0);

    // stop while idle: not ready, no pulse
    stop = 1'b1;
    #1;
    check("stop_blocks_ready", int'(note_ready), 0);
    step();
    check("stop_idle_no_done", int'(note_done), 0);
    stop = 1'b0;
    #1;
    check("ready_after_stop", int'(note_ready), 1);

    // three notes of dur 2 offered back-to-back
    offer(4'd0, 2'd0, 16'd2, w);
    offer(4'd1, 2'd0, 16'd2, w);
    check("bb_second_wait", w, 1);
    offer(4'd2, 2'd0, 16'd2, w);
    check("bb_third_wait", w, 39);
    wait_done(100, n, hi);
    check("bb_second_done", n, 19);
    wait_done(100, n, hi);
    check("bb_third_done_spacing", n, 40);
    repeat (19) step();
    check("bb_busy_gap", int'(busy), 1);
    step();
    check("bb_idle", int'(busy), 0);

    // dur 0 note then a rest of dur 2
    offer(4'd3, 2'd0, 16'd0, w);
    note_tone = 4'd15; note_octave = 2'd0; note_dur = 16'd2; note_valid = 1'b1;
    step();
    check("zero_dur_done", int'(note_done), 1);
    check("zero_dur_ready", int'(note_ready), 1);
    step();
    note_valid = 1'b0;
    check("zero_dur_single", int'(note_done), 0);
    wait_done(100, n, hi);
    check("rest_done", n, 39);
    check("rest_silent", hi, 0);
    repeat (20) step();
    check("rest_idle", int'(busy), 0);

    // P=235 and P=31 half-periods
    offer(4'd0, 2'd1, 16'd3100, w);
    wait_audio(1'b1, 40000, n);
    check("p235_first_rise", n, 30081);
    stop = 1'b1; step(); stop = 1'b0; step();
    offer(4'd11, 2'd3, 16'd1000, w);
    wait_audio(1'b1, 5000, n);
    check("p31_first_rise", n, 3969);
    wait_audio(1'b0, 5000, n);
    check("p31_fall", n, 3968);
    stop = 1'b1; step(); stop = 1'b0; step();

    // reset 15 cycles into PLAY
    offer(4'd0, 2'd3, 16'd5, w);
    repeat (16) step();
    reset = 1'b1;
    #1;
    check("midreset_audio", int'(audio_out), 0);
    check("midreset_done", int'(note_done), 0);
    check("midreset_busy", int'(busy), 0);
    step();
    reset = 1'b0;
    #1;
    check("midreset_ready", int'(note_ready), 1);
    wait_done(60, n, hi);
    check("midreset_no_done", n, 60);
    check("midreset_idle", int'(busy), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
